// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word type and memory responder state encoding
package lc3b_types;

  localparam int LC3B_WIDTH = 16;

  typedef logic [LC3B_WIDTH-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } mem_resp_state_t;

  // Reads always fetch the full word; only stores honour the core's lanes.
  function automatic logic [1:0] pmem_lanes(input logic write, input logic [1:0] byte_enable);
    return write ? byte_enable : 2'b11;
  endfunction

endpackage

// File: rtl/port_hold_buffer.sv
// rtl/port_hold_buffer.sv - per-port done flag and data register, held until advance or request drop
module port_hold_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             request,
  input  logic             advance,
  input  logic             set,
  input  logic             capture,
  input  logic [WIDTH-1:0] load_data,
  output logic             done,
  output logic [WIDTH-1:0] data
);

  // A completion landing on the advance edge belongs to the next instruction,
  // so set wins over both clear causes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (set) begin
      done <= 1'b1;
    end else if (advance || !request) begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (capture) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - I/D port arbiter onto one pmem interface with held responses (option: MEM_RESP_BYPASS_EN)
import lc3b_types::*;

module mem_port_responder #(
  parameter int WIDTH        = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             instruction_request,
  input  logic [WIDTH-1:0] instruction_address,
  output logic [WIDTH-1:0] instr,
  output logic             instruction_response,
  input  logic             data_request,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             data_response,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  output logic [1:0]       pmem_byte_enable,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  mem_resp_state_t state;
  logic [SW-1:0]   starve_cnt;
  logic            i_done, d_done;
  logic [WIDTH-1:0] i_data, d_data;
  logic            i_pend, d_pend;
  logic            grant_i, grant_d;
  logic            i_set, d_set;

  assign i_pend = instruction_request & ~i_done;
  assign d_pend = data_request & ~d_done;

  assign grant_d = (state == IDLE) & d_pend & (~i_pend | (starve_cnt < STARVE_MAX));
  assign grant_i = (state == IDLE) & i_pend & ~grant_d;

  assign i_set = (state == I_ACC) & pmem_resp;
  assign d_set = (state == D_ACC) & pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= D_ACC;
          end else if (grant_i) begin
            state <= I_ACC;
          end
        end
        I_ACC, D_ACC: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts data grants taken past a waiting fetch; saturates so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_pend && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = 2'b11;
    case (state)
      I_ACC: begin
        pmem_read    = 1'b1;
        pmem_address = instruction_address;
      end
      D_ACC: begin
        pmem_read        = ~write_enable;
        pmem_write       = write_enable;
        pmem_address     = mem_address;
        pmem_wdata       = write_enable ? write_data : '0;
        pmem_byte_enable = pmem_lanes(write_enable, mem_byte_enable);
      end
      default: ;
    endcase
  end

  port_hold_buffer #(.WIDTH(WIDTH)) i_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .request   (instruction_request),
    .advance   (advance),
    .set       (i_set),
    .capture   (i_set),
    .load_data (pmem_rdata),
    .done      (i_done),
    .data      (i_data)
  );

  // Stores acknowledge without disturbing the last load result.
  port_hold_buffer #(.WIDTH(WIDTH)) d_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .request   (data_request),
    .advance   (advance),
    .set       (d_set),
    .capture   (d_set & ~write_enable),
    .load_data (pmem_rdata),
    .done      (d_done),
    .data      (d_data)
  );

`ifdef MEM_RESP_BYPASS_EN
  assign instruction_response = instruction_request & (i_done | i_set);
  assign data_response        = data_request & (d_done | d_set);
  assign instr                = i_set ? pmem_rdata : i_data;
  assign mem_rdata            = (d_set & ~write_enable) ? pmem_rdata : d_data;
`else
  assign instruction_response = instruction_request & i_done;
  assign data_response        = data_request & d_done;
  assign instr                = i_data;
  assign mem_rdata            = d_data;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
// tb/tb_mem_port_responder.sv - scoreboard bench for mem_port_responder with a latency-configurable pmem model
module tb_mem_port_responder;

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [15:0] wdata;
    logic [1:0]  be;
  } access_t;

  logic        clk;
  logic        rst_n;
  logic        advance;
  logic        instruction_request;
  logic [15:0] instruction_address;
  logic [15:0] instr;
  logic        instruction_response;
  logic        data_request;
  logic        write_enable;
  logic [15:0] mem_address;
  logic [1:0]  mem_byte_enable;
  logic [15:0] write_data;
  logic [15:0] mem_rdata;
  logic        data_response;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int          passed;
  int          total;
  int          mem_lat;
  logic        inject_resp;
  logic [15:0] mem [int unsigned];
  access_t     acc_log [$];
  logic [15:0] exp_i [$];
  logic [15:0] exp_d [$];

  mem_port_responder #(.WIDTH(16), .STARVE_LIMIT(3)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .advance              (advance),
    .instruction_request  (instruction_request),
    .instruction_address  (instruction_address),
    .instr                (instr),
    .instruction_response (instruction_response),
    .data_request         (data_request),
    .write_enable         (write_enable),
    .mem_address          (mem_address),
    .mem_byte_enable      (mem_byte_enable),
    .write_data           (write_data),
    .mem_rdata            (mem_rdata),
    .data_response        (data_response),
    .pmem_read            (pmem_read),
    .pmem_write           (pmem_write),
    .pmem_address         (pmem_address),
    .pmem_wdata           (pmem_wdata),
    .pmem_byte_enable     (pmem_byte_enable),
    .pmem_rdata           (pmem_rdata),
    .pmem_resp            (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 16'h5555;
  endfunction

  // Physical memory: responds mem_lat strobe-cycles after a strobe appears.
  initial begin
    int wait_cnt;
    access_t a;
    wait_cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (inject_resp) begin
        pmem_resp = 1'b1;
        pmem_rdata = 16'hFFFF;
      end else if (rst_n && (pmem_read || pmem_write)) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          a.addr = pmem_address;
          a.write = pmem_write;
          a.wdata = pmem_wdata;
          a.be = pmem_byte_enable;
          acc_log.push_back(a);
          if (!pmem_write) pmem_rdata = mem_val(pmem_address);
          pmem_resp = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (instr !== 16'h0) $display("FAIL reset_instr: got %h expected 0000", instr); else passed++;
    total++; if (mem_rdata !== 16'h0) $display("FAIL reset_mem_rdata: got %h expected 0000", mem_rdata); else passed++;
    total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {pmem_read, pmem_write}); else passed++;
    total++; if ({instruction_response, data_response} !== 2'b00) $display("FAIL reset_resp: got %b expected 00", {instruction_response, data_response}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    int n0, cyc, exp_lat;
    logic got, rd1;
    logic [15:0] addr1;
    mem[16'h0010] = 16'h1234;
    mem_lat = 3;
    n0 = acc_log.size();
    instruction_address = 16'h0010;
    instruction_request = 1'b1;
    exp_i.push_back(mem_val(16'h0010));
`ifdef MEM_RESP_BYPASS_EN
    exp_lat = 3;
`else
    exp_lat = 4;
`endif
    cyc = 0; got = 1'b0; rd1 = 1'b0; addr1 = 16'h0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin rd1 = pmem_read; addr1 = pmem_address; end
      if (instruction_response) got = 1'b1;
    end
    total++; if (got !== 1'b1) $display("FAIL fetch_timeout: got %b expected 1", got); else passed++;
    total++; if (rd1 !== 1'b1 || addr1 !== 16'h0010) $display("FAIL fetch_strobe_cycle1: got read=%b addr=%h expected read=1 addr=0010", rd1, addr1); else passed++;
    total++; if (cyc !== exp_lat) $display("FAIL fetch_latency: got %0d expected %0d", cyc, exp_lat); else passed++;
    total++; if (instr !== exp_i[0]) $display("FAIL fetch_data: got %h expected %h", instr, exp_i[0]); else passed++;
    void'(exp_i.pop_front());
    repeat (3) @(negedge clk);
    total++; if (instruction_response !== 1'b1 || instr !== 16'h1234) $display("FAIL fetch_hold: got resp=%b instr=%h expected resp=1 instr=1234", instruction_response, instr); else passed++;
    total++; if (acc_log.size() !== n0 + 1) $display("FAIL fetch_single_access: got %0d expected %0d", acc_log.size() - n0, 1); else passed++;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    total++; if (instruction_response !== 1'b0) $display("FAIL fetch_advance_clear: got %b expected 0", instruction_response); else passed++;
    // Request still high: the next instruction re-fetches the same address.
    exp_i.push_back(mem_val(16'h0010));
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (instruction_response) got = 1'b1;
    end
    total++; if (got !== 1'b1 || acc_log.size() !== n0 + 2) $display("FAIL fetch_rerequest: got resp=%b accesses=%0d expected resp=1 accesses=2", got, acc_log.size() - n0); else passed++;
    total++; if (instr !== exp_i[0]) $display("FAIL fetch_rerequest_data: got %h expected %h", instr, exp_i[0]); else passed++;
    void'(exp_i.pop_front());
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    instruction_request = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration;
    int n0, cyc;
    logic got;
    mem[16'h0020] = 16'h2222;
    mem[16'h4000] = 16'h4444;
    mem_lat = 2;
    n0 = acc_log.size();
    instruction_address = 16'h0020;
    mem_address = 16'h4000;
    write_enable = 1'b0;
    instruction_request = 1'b1;
    data_request = 1'b1;
    exp_i.push_back(mem_val(16'h0020));
    exp_d.push_back(mem_val(16'h4000));
    cyc = 0; got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (instruction_response && data_response) got = 1'b1;
    end
    total++; if (got !== 1'b1) $display("FAIL arb_both_resp: got %b expected 1", got); else passed++;
    if (acc_log.size() >= n0 + 2) begin
      total++; if (acc_log[n0].addr !== 16'h4000 || acc_log[n0].write !== 1'b0) $display("FAIL arb_d_first: got addr=%h write=%b expected addr=4000 write=0", acc_log[n0].addr, acc_log[n0].write); else passed++;
      total++; if (acc_log[n0+1].addr !== 16'h0020 || acc_log[n0+1].be !== 2'b11) $display("FAIL arb_i_second: got addr=%h be=%b expected addr=0020 be=11", acc_log[n0+1].addr, acc_log[n0+1].be); else passed++;
    end else begin
      total++; $display("FAIL arb_access_count: got %0d expected 2", acc_log.size() - n0);
    end
    total++; if (instr !== exp_i[0]) $display("FAIL arb_instr: got %h expected %h", instr, exp_i[0]); else passed++;
    total++; if (mem_rdata !== exp_d[0]) $display("FAIL arb_mem_rdata: got %h expected %h", mem_rdata, exp_d[0]); else passed++;
    void'(exp_i.pop_front());
    void'(exp_d.pop_front());
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    total++; if ({instruction_response, data_response} !== 2'b00) $display("FAIL arb_one_advance: got %b expected 00", {instruction_response, data_response}); else passed++;
    instruction_request = 1'b0;
    data_request = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (acc_log.size() !== n0 + 2) $display("FAIL arb_no_extra: got %0d expected 2", acc_log.size() - n0); else passed++;
  endtask

  task automatic test_store;
    int n0, cyc;
    logic got;
    mem_lat = 2;
    n0 = acc_log.size();
    mem_address = 16'h4002;
    write_enable = 1'b1;
    mem_byte_enable = 2'b01;
    write_data = 16'hBEEF;
    data_request = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (data_response) got = 1'b1;
    end
    total++; if (got !== 1'b1) $display("FAIL store_resp: got %b expected 1", got); else passed++;
    if (acc_log.size() == n0 + 1) begin
      total++;
      if (acc_log[n0].write !== 1'b1 || acc_log[n0].wdata !== 16'hBEEF || acc_log[n0].be !== 2'b01 || acc_log[n0].addr !== 16'h4002)
        $display("FAIL store_pmem: got w=%b d=%h be=%b a=%h expected w=1 d=beef be=01 a=4002", acc_log[n0].write, acc_log[n0].wdata, acc_log[n0].be, acc_log[n0].addr);
      else passed++;
    end else begin
      total++; $display("FAIL store_access_count: got %0d expected 1", acc_log.size() - n0);
    end
    repeat (4) @(negedge clk);
    total++; if (data_response !== 1'b1 || acc_log.size() !== n0 + 1) $display("FAIL store_hold: got resp=%b accesses=%0d expected resp=1 accesses=1", data_response, acc_log.size() - n0); else passed++;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    data_request = 1'b0;
    write_enable = 1'b0;
    total++; if (data_response !== 1'b0) $display("FAIL store_advance_clear: got %b expected 0", data_response); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation;
    int n0, cyc, d_before;
    logic i_seen, i_logged;
    mem[16'h0030] = 16'h3030;
    mem_lat = 1;
    n0 = acc_log.size();
    instruction_address = 16'h0030;
    mem_address = 16'h5000;
    write_enable = 1'b0;
    instruction_request = 1'b1;
    data_request = 1'b1;
    exp_i.push_back(mem_val(16'h0030));
    cyc = 0; i_seen = 1'b0;
    while (cyc < 200 && !i_seen) begin
      @(negedge clk);
      cyc++;
      advance = data_response;
      if (instruction_response) i_seen = 1'b1;
    end
    advance = 1'b0;
    d_before = 0; i_logged = 1'b0;
    for (int k = n0; k < acc_log.size(); k++) begin
      if (!i_logged) begin
        if (acc_log[k].addr == 16'h0030) i_logged = 1'b1;
        else d_before++;
      end
    end
    total++; if (i_seen !== 1'b1 || i_logged !== 1'b1) $display("FAIL starve_i_served: got seen=%b logged=%b expected 1 1", i_seen, i_logged); else passed++;
    total++; if (d_before < 1 || d_before > 3) $display("FAIL starve_limit: got %0d data grants before fetch expected 1..3", d_before); else passed++;
    total++; if (instr !== exp_i[0]) $display("FAIL starve_instr: got %h expected %h", instr, exp_i[0]); else passed++;
    void'(exp_i.pop_front());
    instruction_request = 1'b0;
    data_request = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    int n0, cyc;
    logic seen, bad_resp;
    mem_lat = 10;
    n0 = acc_log.size();
    mem_address = 16'h6000;
    write_enable = 1'b0;
    data_request = 1'b1;
    cyc = 0; seen = 1'b0;
    while (cyc < 10 && !seen) begin
      @(negedge clk);
      cyc++;
      if (pmem_read) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL rstmid_strobe: got %b expected 1", seen); else passed++;
    rst_n = 1'b0;
    data_request = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rstmid_drop: got %b expected 0", pmem_read); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad_resp = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (data_response) bad_resp = 1'b1;
    end
    total++; if (bad_resp !== 1'b0 || acc_log.size() !== n0) $display("FAIL rstmid_discard: got resp=%b accesses=%0d expected resp=0 accesses=0", bad_resp, acc_log.size() - n0); else passed++;
  endtask

  task automatic test_bypass;
    int cyc;
    logic seen;
    mem[16'h0040] = 16'h5A5A;
    mem_lat = 2;
    instruction_address = 16'h0040;
    instruction_request = 1'b1;
    exp_i.push_back(mem_val(16'h0040));
    cyc = 0; seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (pmem_resp) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL bypass_resp_cycle: got %b expected 1", seen); else passed++;
`ifdef MEM_RESP_BYPASS_EN
    total++; if (instruction_response !== 1'b1 || instr !== exp_i[0]) $display("FAIL bypass_same_cycle: got resp=%b instr=%h expected resp=1 instr=%h", instruction_response, instr, exp_i[0]); else passed++;
`else
    total++; if (instruction_response !== 1'b0) $display("FAIL bypass_registered_early: got %b expected 0", instruction_response); else passed++;
    @(negedge clk);
    total++; if (instruction_response !== 1'b1 || instr !== exp_i[0]) $display("FAIL bypass_registered: got resp=%b instr=%h expected resp=1 instr=%h", instruction_response, instr, exp_i[0]); else passed++;
`endif
    void'(exp_i.pop_front());
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    instruction_request = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_resp;
    int n0;
    n0 = acc_log.size();
    inject_resp = 1'b1;
    @(negedge clk);
    inject_resp = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({instruction_response, data_response, pmem_read, pmem_write} !== 4'b0000) $display("FAIL idle_resp_ignored: got %b expected 0000", {instruction_response, data_response, pmem_read, pmem_write}); else passed++;
    total++; if (instr !== 16'h5A5A) $display("FAIL idle_resp_instr: got %h expected 5a5a", instr); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    mem_lat = 2;
    inject_resp = 1'b0;
    rst_n = 1'b0;
    advance = 1'b0;
    instruction_request = 1'b0;
    instruction_address = 16'h0;
    data_request = 1'b0;
    write_enable = 1'b0;
    mem_address = 16'h0;
    mem_byte_enable = 2'b11;
    write_data = 16'h0;
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_starvation();
    test_reset_mid_access();
    test_bypass();
    test_idle_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Memory-side responder for the pipelined LC-3b core's split request/response ports: one instruction fetch port and one data load/store port.
- Arbitrates both ports onto a single physical memory interface (pmem_*).
- Captures each completed access in a per-port hold buffer and keeps the response asserted until the core's pipeline-wide `advance` consumes it.
- Sits between the CPU datapath and the cache/memory hierarchy.

Parameters:
- WIDTH, 16, address and data width (lc3b_word).
- STARVE_LIMIT, 3, consecutive data grants allowed while an instruction request waits before the instruction port is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- advance  in  1  core pipeline advance; consumes held responses
- instruction_request  in  1  fetch request, level-held until consumed
- instruction_address  in  WIDTH  fetch address
- instr  out  WIDTH  fetched word
- instruction_response  out  1  fetch data valid, held until advance
- data_request  in  1  load/store request, level-held
- write_enable  in  1  1 = store, 0 = load
- mem_address  in  WIDTH  data address
- mem_byte_enable  in  2  store byte lanes
- write_data  in  WIDTH  store data
- mem_rdata  out  WIDTH  load data
- data_response  out  1  load/store complete, held until advance
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_address  out  WIDTH  physical address
- pmem_wdata  out  WIDTH  physical write data
- pmem_byte_enable  out  2  physical byte lanes (2'b11 on reads)
- pmem_rdata  in  WIDTH  physical read data
- pmem_resp  in  1  physical access complete (one-cycle pulse)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` asynchronous active-low.
- Reset values:
  - State = IDLE; i_done = d_done = 0; starve count = 0.
  - instr = mem_rdata = 0; all pmem strobes = 0; both responses = 0.
  - Assertion of rst_n mid-access drops pmem strobes immediately and discards the access.
- FSM states: IDLE, I_ACC, D_ACC.
- Pending request definitions:
  - I pending = instruction_request & !i_done.
  - D pending = data_request & !d_done.
- IDLE grant selection:
  - Grant D if D is pending and (I is not pending or starve count < STARVE_LIMIT).
  - Otherwise grant I if I is pending.
  - Transition on the next edge.
- Starve count: increments on each D grant while I is pending; clears on any I grant.
- Access states (I_ACC / D_ACC):
  - pmem_read/pmem_write/address/wdata/byte_enable are driven combinationally from the state and the granted port's live inputs.
  - Strobes are held until pmem_resp.
  - On the edge where pmem_resp=1: load the hold buffer (read data or store ack), set the done flag, return to IDLE.
- Latency without bypass: request first visible in cycle 0 → strobe in cycle 1 → pmem_resp in cycle N → response asserted from cycle N+1.
- Response hold:
  - instruction_response = i_done; data_response = d_done.
  - Held while the request stays high.
  - Cleared on the edge with advance=1.
  - Cleared if the request drops.
- Simultaneous advance and pmem_resp for the same port: done flag is set, not cleared; the new result belongs to the next instruction.
- Response gating: no port's response is asserted without its request.
- Re-request: a request with the same address in the next instruction after advance is issued as a new access; no address-match shortcut.
- pmem_resp while in IDLE: ignored.

Optional Feature:
- MEM_RESP_BYPASS_EN defined:
  - In the pmem_resp cycle, the granted port's response is asserted combinationally.
  - instr/mem_rdata are driven directly from pmem_rdata in that cycle.
  - Saves one cycle per access; the buffer still loads for subsequent hold cycles.
- Undefined: responses are registered only (latency N+1).

Decomposition:
- Shared package (lc3b_types): lc3b_word; new enum mem_resp_state_t {IDLE, I_ACC, D_ACC}.
- One natural sub-module, port_hold_buffer (done flag + data register + advance/request clear), instantiated twice.

Test Plan:
1. Fetch only, addr 0x0010, pmem_rdata 0x1234 with resp 3 cycles after the strobe → instr=0x1234, instruction_response held until advance pulse, then 0.
2. Simultaneous I request (0x0020) and D load (0x4000) → pmem_address=0x4000 first; I serviced after D completes; both responses high together; one advance clears both.
3. Store 0xBEEF to 0x4002, byte_enable 2'b01 → pmem_write=1, pmem_wdata=0xBEEF, pmem_byte_enable=2'b01; data_response held; no second write while held.
4. Continuous D requests with I pending, STARVE_LIMIT=3 → I granted after 3 D grants.
5. rst_n low during D_ACC with pmem_read high → pmem_read=0 immediately; state IDLE; no response after release.
6. MEM_RESP_BYPASS_EN defined, fetch with pmem_rdata 0x5A5A → instruction_response=1 and instr=0x5A5A in the pmem_resp cycle itself.
